// File: rtl/cla_serial_adder_if.sv
// rtl/cla_serial_adder_if.sv - operand/result handshake bundle for cla_serial_adder
//
// Purpose: groups the operand stream (in_*), result stream (out_*) and busy
//          flag of the nibble-serial adder.
// Ports (signals):
//   in_valid, in_ready, in_a[WIDTH], in_b[WIDTH], in_cin  - operand handshake
//   out_valid, out_ready, out_sum[WIDTH], out_cout        - result handshake
//   busy                                                  - operation in flight
//   out_ovf                                               - signed overflow (CLA_SERIAL_OVF_EN)
// Modports: master = producer/consumer side, slave = adder side.
// Optional feature macro: CLA_SERIAL_OVF_EN.

interface cla_serial_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             busy;
`ifdef CLA_SERIAL_OVF_EN
   logic             out_ovf;
`endif

   modport master (
`ifdef CLA_SERIAL_OVF_EN
      input  out_ovf,
`endif
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, busy
   );

   modport slave (
`ifdef CLA_SERIAL_OVF_EN
      output out_ovf,
`endif
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout, busy
   );
endinterface

// File: rtl/cla_serial_adder.sv
// rtl/cla_serial_adder.sv - nibble-serial WIDTH-bit adder around one 4-bit CLA slice
//
// Purpose: accepts two WIDTH-bit operands plus carry-in, adds them one nibble
//          per cycle (LSB nibble first) through a single combinational 4-bit
//          carry-lookahead slice with a registered inter-nibble carry, and
//          presents the full-width sum and carry-out with a valid/ready handshake.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - cla_serial_adder_if.slave (in_* operand stream, out_* result stream, busy,
//          out_ovf when CLA_SERIAL_OVF_EN is defined)
// Optional feature macro: CLA_SERIAL_OVF_EN (signed overflow flag out_ovf).
// Modules: cla_serial_adder_slice (4-bit CLA), cla_serial_adder (top).

module cla_serial_adder_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] sum,
   output logic       c_out
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is expanded directly from g/p and c_in, so no carry ripples
   // through the slice.
   assign c[0] = c_in;
   assign c[1] = g[0] | (p[0] & c_in);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c_in);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c_in);

   assign sum   = p ^ c[3:0];
   assign c_out = c[4];
endmodule

module cla_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   cla_serial_adder_if.slave    bus
);
   localparam int N     = WIDTH / 4;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   logic [3:0]       slice_a;
   logic [3:0]       slice_b;
   logic [3:0]       slice_sum;
   logic             slice_cout;
   logic             last_nibble;

   // Nibble base is idx*4; the {idx,2'b00} form keeps the select index free of
   // a multiplier.
   assign slice_a     = a_q[{idx, 2'b00} +: 4];
   assign slice_b     = b_q[{idx, 2'b00} +: 4];
   assign last_nibble = (idx == LAST_IDX);

   cla_serial_adder_slice u_slice (
      .a     (slice_a),
      .b     (slice_b),
      .c_in  (carry_q),
      .sum   (slice_sum),
      .c_out (slice_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid) state_d = CALC;
         CALC:    if (last_nibble)  state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q     <= bus.in_a;
                  b_q     <= bus.in_b;
                  carry_q <= bus.in_cin;
                  idx     <= '0;
               end
            end
            CALC: begin
               sum_q[{idx, 2'b00} +: 4] <= slice_sum;
               carry_q                  <= slice_cout;
               if (last_nibble) begin
                  cout_q <= slice_cout;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CLA_SERIAL_OVF_EN
   logic ovf_q;

   // Signed overflow: operands share a sign and the result's MSB (bit 3 of the
   // final nibble) differs from it.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (state_q == CALC && last_nibble) begin
         ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[3] != a_q[WIDTH-1]);
      end
   end

   assign bus.out_ovf = ovf_q;
`endif

   // All outputs come from registers or a state decode only.
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_sum   = sum_q;
   assign bus.out_cout  = cout_q;
endmodule

// File: tb/tb_cla_serial_adder.sv
// tb/tb_cla_serial_adder.sv - self-checking bench for cla_serial_adder

module tb_cla_serial_adder;
   localparam int W = 16;
   localparam int N = W / 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cla_serial_adder_if #(.WIDTH(16)) bus16 ();
   cla_serial_adder_if #(.WIDTH(4))  bus4 ();

   cla_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
   cla_serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: an accepted operation yields a+b+cin, and its result
   // is presented N edges after the accept edge until out_ready is seen.
   logic        m_busy = 1'b0;
   int          m_cnt  = 0;
   logic [16:0] m_res  = '0;
   logic        m_ovf  = 1'b0;

   function automatic logic [16:0] add_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic cin);
      return {1'b0, a} + {1'b0, b} + {16'd0, cin};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_cnt  <= 0;
      end else if (!m_busy) begin
         if (bus16.in_valid) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
            m_res  <= add_model(bus16.in_a, bus16.in_b, bus16.in_cin);
            m_ovf  <= (bus16.in_a[15] == bus16.in_b[15]) &&
                      (add_model(bus16.in_a, bus16.in_b, bus16.in_cin) >> 15 & 17'd1) != {16'd0, bus16.in_a[15]};
         end
      end else if (m_cnt < N) begin
         m_cnt <= m_cnt + 1;
      end else if (bus16.out_ready) begin
         m_busy <= 1'b0;
      end
   end

   always @(negedge clk) begin
      chk("in_ready",  {31'd0, bus16.in_ready},  {31'd0, !m_busy});
      chk("busy",      {31'd0, bus16.busy},      {31'd0, m_busy});
      chk("out_valid", {31'd0, bus16.out_valid}, {31'd0, (m_busy && m_cnt == N)});
      if (m_busy && m_cnt == N) begin
         chk("model_sum",  {16'd0, bus16.out_sum},  {16'd0, m_res[15:0]});
         chk("model_cout", {31'd0, bus16.out_cout}, {31'd0, m_res[16]});
`ifdef CLA_SERIAL_OVF_EN
         chk("model_ovf",  {31'd0, bus16.out_ovf},  {31'd0, m_ovf});
`endif
      end
   end

   logic last_ovf = 1'b0;

   // One operation on the 16-bit DUT. While DONE is held for `hold` cycles a
   // new operand pair (na, nb) is offered; it must only be taken after release.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic [15:0] es, input logic ec, input int hold,
                        input logic [15:0] na, input logic [15:0] nb);
      int   t;
      int   cyc;
      logic seen_ready;
      logic [15:0] held_sum;
      bus16.in_a     = a;
      bus16.in_b     = b;
      bus16.in_cin   = cin;
      bus16.in_valid = 1'b1;
      t = 0;
      while (!bus16.in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("accept_wait", {31'd0, (t < 100)}, 32'd1);
      @(posedge clk);
      #1;
      bus16.in_valid = 1'b0;
      bus16.in_a     = ~a;
      bus16.in_b     = ~b;
      bus16.in_cin   = ~cin;
      cyc        = 0;
      seen_ready = bus16.in_ready;
      while (!bus16.out_valid && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         seen_ready |= bus16.in_ready;
      end
      chk("latency",  cyc, N);
      chk("lit_sum",  {16'd0, bus16.out_sum}, {16'd0, es});
      chk("lit_cout", {31'd0, bus16.out_cout}, {31'd0, ec});
`ifdef CLA_SERIAL_OVF_EN
      last_ovf = bus16.out_ovf;
`endif
      held_sum = bus16.out_sum;
      if (hold > 0) begin
         bus16.in_a     = na;
         bus16.in_b     = nb;
         bus16.in_cin   = 1'b0;
         bus16.in_valid = 1'b1;
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         seen_ready |= bus16.in_ready;
         chk("hold_valid", {31'd0, bus16.out_valid}, 32'd1);
         chk("hold_sum",   {16'd0, bus16.out_sum}, {16'd0, held_sum});
      end
      bus16.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus16.out_ready = 1'b0;
      chk("ready_low_while_busy", {31'd0, seen_ready}, 32'd0);
      chk("in_ready_after_hs",    {31'd0, bus16.in_ready}, 32'd1);
      chk("valid_after_hs",       {31'd0, bus16.out_valid}, 32'd0);
   endtask

   initial begin
      int t;
      int cyc;
      bus16.in_valid  = 1'b0;
      bus16.in_a      = '0;
      bus16.in_b      = '0;
      bus16.in_cin    = 1'b0;
      bus16.out_ready = 1'b0;
      bus4.in_valid   = 1'b0;
      bus4.in_a       = '0;
      bus4.in_b       = '0;
      bus4.in_cin     = 1'b0;
      bus4.out_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      chk("rst_in_ready",  {31'd0, bus16.in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, bus16.out_valid}, 32'd0);
      chk("rst_busy",      {31'd0, bus16.busy},      32'd0);
      chk("rst_out_sum",   {16'd0, bus16.out_sum},   32'd0);
      chk("rst_out_cout",  {31'd0, bus16.out_cout},  32'd0);
`ifdef CLA_SERIAL_OVF_EN
      chk("rst_out_ovf",   {31'd0, bus16.out_ovf},   32'd0);
`endif

      // Full ripple across all nibbles.
      do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0, 16'h0, 16'h0);
      // Backpressure, new operands offered while DONE is held.
      do_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 10, 16'h0102, 16'h0304);
      do_op(16'h0102, 16'h0304, 1'b0, 16'h0406, 1'b0, 0, 16'h0, 16'h0);

      // Reset sampled at the second CALC edge abandons the operation.
      bus16.in_a     = 16'h5555;
      bus16.in_b     = 16'h1111;
      bus16.in_cin   = 1'b1;
      bus16.in_valid = 1'b1;
      t = 0;
      while (!bus16.in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #1;
      bus16.in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_valid",    {31'd0, bus16.out_valid}, 32'd0);
      chk("abort_in_ready", {31'd0, bus16.in_ready},  32'd1);
      chk("abort_sum",      {16'd0, bus16.out_sum},   32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_result", {31'd0, bus16.out_valid}, 32'd0);
      do_op(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 0, 16'h0, 16'h0);

`ifdef CLA_SERIAL_OVF_EN
      do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 0, 16'h0, 16'h0);
      chk("ovf_pos", {31'd0, last_ovf}, 32'd1);
      do_op(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 0, 16'h0, 16'h0);
      chk("ovf_neg", {31'd0, last_ovf}, 32'd1);
      do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0, 16'h0, 16'h0);
      chk("ovf_none", {31'd0, last_ovf}, 32'd0);
`endif

      // Single-nibble instance.
      bus4.in_a     = 4'hF;
      bus4.in_b     = 4'hF;
      bus4.in_cin   = 1'b1;
      bus4.in_valid = 1'b1;
      t = 0;
      while (!bus4.in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("w4_accept_wait", {31'd0, (t < 100)}, 32'd1);
      @(posedge clk);
      #1;
      bus4.in_valid = 1'b0;
      bus4.in_a     = 4'h0;
      bus4.in_b     = 4'h0;
      chk("w4_busy", {31'd0, bus4.busy}, 32'd1);
      cyc = 0;
      while (!bus4.out_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("w4_latency", cyc, 1);
      chk("w4_sum",  {28'd0, bus4.out_sum}, 32'hF);
      chk("w4_cout", {31'd0, bus4.out_cout}, 32'd1);
      bus4.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus4.out_ready = 1'b0;
      chk("w4_in_ready_after_hs", {31'd0, bus4.in_ready}, 32'd1);
      chk("w4_valid_after_hs",    {31'd0, bus4.out_valid}, 32'd0);

      repeat (2) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
